ram_8x8: RTL and testbench

Small synchronous memory of 8 words x 8 bits with a registered read port and a write port. Contents load a fixed pattern on reset, so after reset the block acts as a lookup ROM that can be overwritten at run time. It is a leaf storage element for sequential datapath blocks needing a few bytes of addressable state, with reads sequenced one address per clock.

---
 rtl/ram_8x8.sv | 57 +++++
 tb/tb_ram_8x8.sv | 135 +++++++++++++
 2 files changed

// File: rtl/ram_8x8.sv
// Small synchronous RAM with a registered read port. A reset loads the pattern i*17 into
// entry i, so the block starts out as a lookup table that can be overwritten at run time.
module ram_8x8 #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] add,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  valid_r;

    // Init pattern (idx * 17) truncated to the word width, which gives the modulo for free.
    function automatic logic [DATA_WIDTH-1:0] init_word(input int idx);
        int prod;
        prod = idx * 17;
        return prod[DATA_WIDTH-1:0];
    endfunction

    // Storage: reload the init pattern on reset, otherwise accept writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= init_word(i);
            end
        end else if (wr) begin
            mem_r[add] <= data_in;
        end
    end

    // Read port: samples the array before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r <= {DATA_WIDTH{1'b0}};
            valid_r    <= 1'b0;
        end else if (rd) begin
            data_out_r <= mem_r[add];
            valid_r    <= 1'b1;
        end else begin
            valid_r    <= 1'b0;
        end
    end

    assign data_out = data_out_r;
    assign valid    = valid_r;

endmodule

// File: tb/tb_ram_8x8.sv
// Directed bench for ram_8x8: a vector table for the default 8x8 instance plus a short
// hand-written sequence for a 4-bit x 4-word instance.
module tb_ram_8x8;

    typedef struct {
        logic       rst;
        logic       rd;
        logic       wr;
        logic [2:0] add;
        logic [7:0] din;
        logic [7:0] exp_data;
        logic       exp_valid;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [2:0] add = 3'd0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       valid;

    logic       s_rst = 1'b1, s_rd = 1'b0, s_wr = 1'b0;
    logic [1:0] s_add = 2'd0;
    logic [3:0] s_data_in = 4'h0;
    logic [3:0] s_data_out;
    logic       s_valid;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    ram_8x8 dut (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .add(add),
        .data_in(data_in), .data_out(data_out), .valid(valid)
    );

    ram_8x8 #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) dut_small (
        .clk(clk), .rst(s_rst), .rd(s_rd), .wr(s_wr), .add(s_add),
        .data_in(s_data_in), .data_out(s_data_out), .valid(s_valid)
    );

    task automatic add_vec(input logic r, input logic rdv, input logic wrv, input logic [2:0] a,
                           input logic [7:0] d, input logic [7:0] ed, input logic ev);
        vec_t v;
        v.rst = r; v.rd = rdv; v.wr = wrv; v.add = a; v.din = d;
        v.exp_data = ed; v.exp_valid = ev;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic small_step(input logic r, input logic rdv, input logic wrv,
                              input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        s_rst = r; s_rd = rdv; s_wr = wrv; s_add = a; s_data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, then sequential read of the init pattern
        add_vec(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        add_vec(1'b1, 1'b1, 1'b1, 3'd4, 8'hEE, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            add_vec(1'b0, 1'b1, 1'b0, 3'(i), 8'h00, 8'(i * 17), 1'b1);
        end
        // Read hold
        add_vec(1'b0, 1'b1, 1'b0, 3'd5, 8'h00, 8'h55, 1'b1);
        add_vec(1'b0, 1'b0, 1'b0, 3'd2, 8'h00, 8'h55, 1'b0);
        // Write then read, neighbour untouched
        add_vec(1'b0, 1'b0, 1'b1, 3'd3, 8'hA5, 8'h55, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 3'd3, 8'h00, 8'hA5, 1'b1);
        add_vec(1'b0, 1'b1, 1'b0, 3'd4, 8'h00, 8'h44, 1'b1);
        // Read-before-write at the same address
        add_vec(1'b0, 1'b1, 1'b1, 3'd6, 8'h3C, 8'h66, 1'b1);
        add_vec(1'b0, 1'b1, 1'b0, 3'd6, 8'h00, 8'h3C, 1'b1);
        // Writes, then reset during a read discards them
        add_vec(1'b0, 1'b0, 1'b1, 3'd1, 8'hFF, 8'h3C, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 3'd1, 8'h00, 8'hFF, 1'b1);
        add_vec(1'b0, 1'b0, 1'b1, 3'd2, 8'h99, 8'hFF, 1'b0);
        add_vec(1'b1, 1'b1, 1'b0, 3'd1, 8'h00, 8'h00, 1'b0);
        add_vec(1'b0, 1'b1, 1'b0, 3'd1, 8'h00, 8'h11, 1'b1);
        add_vec(1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 8'h22, 1'b1);
        add_vec(1'b0, 1'b1, 1'b0, 3'd6, 8'h00, 8'h66, 1'b1);
        add_vec(1'b0, 1'b1, 1'b0, 3'd3, 8'h00, 8'h33, 1'b1);
        // Read and write at different addresses in one cycle
        add_vec(1'b0, 1'b1, 1'b1, 3'd7, 8'h00, 8'h77, 1'b1);
        add_vec(1'b0, 1'b1, 1'b1, 3'd0, 8'h5A, 8'h00, 1'b1);
        add_vec(1'b0, 1'b1, 1'b1, 3'd5, 8'hC3, 8'h55, 1'b1);
        add_vec(1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 8'h5A, 1'b1);
        add_vec(1'b0, 1'b1, 1'b0, 3'd5, 8'h00, 8'hC3, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; rd = vecs[i].rd; wr = vecs[i].wr;
            add = vecs[i].add; data_in = vecs[i].din;
            @(posedge clk);
            #1;
            check("data_out", i, data_out, vecs[i].exp_data);
            check("valid", i, {7'd0, valid}, {7'd0, vecs[i].exp_valid});
        end
        @(negedge clk);
        rd = 1'b0; wr = 1'b0;

        // Narrow instance: init pattern is i*17 mod 16 = i
        small_step(1'b1, 1'b0, 1'b0, 2'd0, 4'h0);
        check("small_rst_data", 0, {4'd0, s_data_out}, 8'h00);
        check("small_rst_valid", 0, {7'd0, s_valid}, 8'h00);
        for (int i = 0; i < 4; i++) begin
            small_step(1'b0, 1'b1, 1'b0, 2'(i), 4'h0);
            check("small_read", i, {4'd0, s_data_out}, 8'(i));
            check("small_valid", i, {7'd0, s_valid}, 8'h01);
        end
        small_step(1'b0, 1'b1, 1'b1, 2'd2, 4'hF);
        check("small_rbw", 0, {4'd0, s_data_out}, 8'h02);
        small_step(1'b0, 1'b1, 1'b0, 2'd2, 4'h0);
        check("small_wr", 0, {4'd0, s_data_out}, 8'h0F);
        small_step(1'b0, 1'b0, 1'b0, 2'd3, 4'h0);
        check("small_hold", 0, {4'd0, s_data_out}, 8'h0F);
        check("small_idle_valid", 0, {7'd0, s_valid}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
